// File: rtl/alarm_pkg.sv
// alarm_pkg: shared ring-controller state encoding and default timing constants
package alarm_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2,
      DONE   = 2'd3
   } state_t;
   localparam int DEF_CLK_HZ         = 2000;
   localparam int DEF_RING_SECONDS   = 60;
   localparam int DEF_SNOOZE_SECONDS = 300;
   localparam int DEF_MAX_SNOOZE     = 3;
endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: one-cycle tick every CLK_HZ cycles, restarted by clr
module sec_tick_gen #(
   parameter int CLK_HZ = 2000
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   output logic tick
);
   localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   logic [DW-1:0] div;
   assign tick = (div == DW'(CLK_HZ - 1));
   // divider runs 0..CLK_HZ-1 and restarts from zero on clr
   always_ff @(posedge clk)
      if (!rstn || clr) div <= '0;
      else div <= tick ? '0 : div + DW'(1);
endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm ring FSM with two-tone buzzer, ring timeout, snooze and stop
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int CLK_HZ         = DEF_CLK_HZ,
   parameter int RING_SECONDS   = DEF_RING_SECONDS,
   parameter int SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
   parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       bell_en,
   input  logic       time_match,
   input  logic       snooze_key,
   input  logic       stop_key,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);
   localparam int SEC_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
   localparam int SW      = $clog2(SEC_MAX + 1);
   state_t        state, nxt;
   logic          tm_d, sk_d, st_d;
   logic          tm_rise, sk_rise, st_rise;
   logic          entry, tick, expire;
   logic [SW-1:0] sec, sec_lim;
   logic [1:0]    tone_cnt, cnt;
   assign tm_rise = time_match & ~tm_d;
   assign sk_rise = snooze_key & ~sk_d;
   assign st_rise = stop_key & ~st_d;
   assign entry   = (nxt != state);
   assign sec_lim = (state == RING) ? SW'(RING_SECONDS - 1) : SW'(SNOOZE_SECONDS - 1);
   assign expire  = tick && (sec == sec_lim);
   sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk (clk),
      .rstn(rstn),
      .clr (entry),
      .tick(tick)
   );
   // next state: bell_en low beats stop, stop beats snooze, snooze beats timeout
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (bell_en && tm_rise) ? RING : IDLE;
         RING:    nxt = (!bell_en || st_rise) ? DONE
                      : (sk_rise && cnt < 2'(MAX_SNOOZE)) ? SNOOZE
                      : expire ? DONE : RING;
         SNOOZE:  nxt = (!bell_en || st_rise) ? DONE : expire ? RING : SNOOZE;
         default: nxt = time_match ? DONE : IDLE;
      endcase
   end
   // state, key edge history (held high in reset so power-up levels are not edges), snooze count
   always_ff @(posedge clk)
      if (!rstn) begin
         state <= IDLE;
         tm_d  <= 1'b1;
         sk_d  <= 1'b1;
         st_d  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= nxt;
         tm_d  <= time_match;
         sk_d  <= snooze_key;
         st_d  <= stop_key;
         cnt   <= (nxt == IDLE) ? '0 : (state == RING && nxt == SNOOZE) ? cnt + 2'd1 : cnt;
      end
   // seconds elapsed in the current state and tone phase, both restarted on each state entry
   always_ff @(posedge clk)
      if (!rstn) begin
         sec      <= '0;
         tone_cnt <= '0;
      end else begin
         sec      <= entry ? '0 : (tick && sec != '1) ? sec + SW'(1) : sec;
         tone_cnt <= entry ? '0 : (state == RING) ? tone_cnt + 2'd1 : tone_cnt;
      end
   // registered outputs: even seconds toggle at CLK_HZ/2, odd seconds at CLK_HZ/4
   always_ff @(posedge clk)
      if (!rstn) begin
         buzzer     <= 1'b0;
         ringing    <= 1'b0;
         snoozing   <= 1'b0;
         snooze_cnt <= '0;
      end else begin
         buzzer     <= (state == RING) && (sec[0] ? tone_cnt[1] : tone_cnt[0]);
         ringing    <= (state == RING);
         snoozing   <= (state == SNOOZE);
         snooze_cnt <= cnt;
      end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: vector table, directed corner sequences and random run against a cycle model
module tb_alarm_ring_ctrl;
   localparam int HZ = 4, RS = 3, SS = 2, MS = 2;
   logic clk = 1'b0, rstn = 1'b0, bell_en = 1'b1, time_match = 1'b1, snooze_key = 1'b0, stop_key = 1'b0;
   logic buzzer, ringing, snoozing;
   logic [1:0] snooze_cnt;
   int total = 0, bad = 0;
   string mode = "idle";
   int el = 0, used = 0;
   bit tp = 1'b1, kp = 1'b1, sp = 1'b1;
   logic e_buz = 1'b0, e_ring = 1'b0, e_snz = 1'b0;
   logic [1:0] e_cnt = 2'd0;
   typedef struct packed {
      logic rstn, bell, tm, sk, st, buz, ring, snz;
      logic [1:0] cnt;
   } vec_t;
   vec_t tbl[$];

   alarm_ring_ctrl #(.CLK_HZ(HZ), .RING_SECONDS(RS), .SNOOZE_SECONDS(SS), .MAX_SNOOZE(MS)) dut (
      .clk(clk), .rstn(rstn), .bell_en(bell_en), .time_match(time_match),
      .snooze_key(snooze_key), .stop_key(stop_key),
      .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, b, t, k, s, z, g, n, logic [1:0] c);
      return {r, b, t, k, s, z, g, n, c};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Outputs seen after an edge describe the mode held before that edge;
   // mode timing is counted in whole cycles since the mode was entered.
   task automatic model_step();
      bit tr, kr, sr;
      string nm;
      if (!rstn) begin
         mode = "idle"; el = 0; used = 0; tp = 1'b1; kp = 1'b1; sp = 1'b1;
         e_buz = 1'b0; e_ring = 1'b0; e_snz = 1'b0; e_cnt = 2'd0;
         return;
      end
      e_ring = (mode == "ring");
      e_snz  = (mode == "snooze");
      e_cnt  = 2'(used);
      e_buz  = (mode == "ring") && ((((el / HZ) % 2) == 0) ? (el % 2 == 1) : ((el / 2) % 2 == 1));
      tr = time_match && !tp;
      kr = snooze_key && !kp;
      sr = stop_key && !sp;
      nm = mode;
      if (mode == "idle" && bell_en && tr) nm = "ring";
      else if ((mode == "ring" || mode == "snooze") && (!bell_en || sr)) nm = "done";
      else if (mode == "ring" && kr && used < MS) begin nm = "snooze"; used++; end
      else if (mode == "ring" && el + 1 == RS * HZ) nm = "done";
      else if (mode == "snooze" && el + 1 == SS * HZ) nm = "ring";
      else if (mode == "done" && !time_match) begin nm = "idle"; used = 0; end
      el = (nm == mode) ? el + 1 : 0;
      mode = nm;
      tp = time_match; kp = snooze_key; sp = stop_key;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("model t=%0t", $time), {buzzer, ringing, snoozing, snooze_cnt}, {e_buz, e_ring, e_snz, e_cnt});
   endtask

   initial begin
      logic [0:11] pat;
      vec_t v;
      int n, q;
      pat = 12'b0101_0011_0101;
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'd0));
      for (int j = 0; j < 12; j++) tbl.push_back(mk(1, 1, 1, 0, 0, pat[j], 1, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0));

      // power-up with the time already matching must stay silent
      rstn = 1'b0; time_match = 1'b1; bell_en = 1'b1;
      cyc(); cyc();
      rstn = 1'b1; n = 0;
      for (int i = 0; i < 20; i++) begin cyc(); n += int'(ringing || buzzer); end
      chk("pwr_quiet", 8'(n), 8'd0);

      // vector table: reset, match rise, two-tone ring, timeout, done, idle
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         rstn = v.rstn; bell_en = v.bell; time_match = v.tm; snooze_key = v.sk; stop_key = v.st;
         cyc();
         chk($sformatf("tbl[%0d]", i), {buzzer, ringing, snoozing, snooze_cnt}, {v.buz, v.ring, v.snz, v.cnt});
      end

      // snooze twice, third snooze ignored, then stop+snooze together
      cyc();
      time_match = 1'b1; cyc();
      repeat (4) cyc();
      snooze_key = 1'b1; cyc(); snooze_key = 1'b0; cyc();
      chk("snz1_on", {snoozing, snooze_cnt}, 8'b101);
      n = 1; q = 0;
      for (int i = 0; i < 20 && snoozing; i++) begin
         cyc();
         if (snoozing) begin n++; q += int'(buzzer); end
      end
      chk("snz_len", 8'(n), 8'd8);
      chk("snz_quiet", 8'(q), 8'd0);
      chk("rering1", ringing, 1);
      snooze_key = 1'b1; cyc(); snooze_key = 1'b0; cyc();
      chk("snz2_on", {snoozing, snooze_cnt}, 8'b110);
      for (int i = 0; i < 20 && !ringing; i++) cyc();
      chk("rering2", ringing, 1);
      snooze_key = 1'b1; cyc(); snooze_key = 1'b0;
      repeat (2) cyc();
      chk("snz3_ignored", {ringing, snoozing, snooze_cnt}, 8'b1010);
      stop_key = 1'b1; snooze_key = 1'b1; cyc();
      stop_key = 1'b0; snooze_key = 1'b0; cyc();
      chk("stop_snz", {buzzer, ringing, snoozing, snooze_cnt}, 8'b00010);
      repeat (3) cyc();
      chk("done_hold", {ringing, snoozing, snooze_cnt}, 8'b0010);
      time_match = 1'b0; cyc(); cyc();
      chk("idle_clr", snooze_cnt, 0);

      // bell_en dropped while snoozing
      time_match = 1'b1; cyc(); cyc();
      snooze_key = 1'b1; cyc(); snooze_key = 1'b0;
      for (int i = 0; i < 10 && !snoozing; i++) cyc();
      chk("wait_snz", snoozing, 1);
      bell_en = 1'b0; cyc(); cyc();
      chk("bell_drop", {ringing, snoozing, snooze_cnt}, 8'b0001);
      bell_en = 1'b1;
      repeat (5) cyc();
      chk("done_stay", {ringing, snoozing, snooze_cnt}, 8'b0001);
      time_match = 1'b0; cyc(); cyc();
      chk("idle_clr2", snooze_cnt, 0);

      // reset pulse mid-ring, no re-ring while the match persists
      time_match = 1'b1; cyc();
      repeat (3) cyc();
      chk("ring_pre_rst", ringing, 1);
      rstn = 1'b0; cyc();
      chk("rst_mid", {buzzer, ringing, snoozing, snooze_cnt}, 0);
      rstn = 1'b1; n = 0;
      repeat (10) begin cyc(); n += int'(ringing || buzzer); end
      chk("no_rering", 8'(n), 8'd0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rstn    = ($urandom_range(199) != 0);
         bell_en = ($urandom_range(49) != 0);
         if ($urandom_range(7) == 0) time_match = ~time_match;
         if ($urandom_range(5) == 0) snooze_key = ~snooze_key;
         if ($urandom_range(29) == 0) stop_key = ~stop_key;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
